// File: rtl/if_scratch_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_scratch_loader_pkg
//  Description : Shared definitions for the scratchpad loaders: loader FSM
//                state encoding and the modulo pointer-advance helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_scratch_loader_pkg;

    // Loader FSM states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        c_idle  = 2'd0,
        c_load  = 2'd1,
        c_drain = 2'd2
    } load_state_t;

    // Next value of a circular pointer of the given modulus (wraps to 0)
    function automatic int unsigned wrap_next(input int unsigned ptr,
                                              input int unsigned modulus);
        return (ptr >= modulus - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage : if_scratch_loader_pkg
`default_nettype wire

// File: rtl/if_scratch_loader_wrap_counter.sv
`default_nettype none
// ============================================================================
//  Module      : wrap_pointer_counter
//  Description : Modulo-MODULUS counter with increment enable and
//                synchronous active-high reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module wrap_pointer_counter
    import if_scratch_loader_pkg::*;
#(
    parameter int unsigned WIDTH   = 9,
    parameter int unsigned MODULUS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Advance the pointer on each enabled cycle, wrapping at MODULUS-1
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc_en) begin
            r_count <= WIDTH'(wrap_next(32'(r_count), MODULUS));
        end
    end

    assign o_count = r_count;

endmodule : wrap_pointer_counter
`default_nettype wire

// File: rtl/if_scratch_loader.sv
`default_nettype none
// ============================================================================
//  Module      : if_scratch_loader
//  Description : Write-side controller for the IF scratchpad. Accepts cells
//                over valid/ready, writes them into a circular scratchpad,
//                tracks occupancy against checker releases and signals row
//                and stream completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_scratch_loader
    import if_scratch_loader_pkg::*;
#(
    parameter int unsigned IF_CELL_SIZE    = 8,
    parameter int unsigned IF_ADDRESS_SIZE = 8,
    parameter int unsigned CELL_NUMS       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [IF_CELL_SIZE-1:0]  in_data,
    input  logic                     in_last,
    input  logic                     in_eol,
    output logic                     in_ready,
    input  logic                     release_en,
    input  logic [IF_ADDRESS_SIZE:0] release_num,
    output logic                     scratch_wr_en,
    output logic [IF_ADDRESS_SIZE:0] scratch_wr_addr,
    output logic [IF_CELL_SIZE-1:0]  scratch_wr_data,
    output logic                     write_cnt_if,
    output logic [IF_ADDRESS_SIZE:0] write_addr_if,
    output logic [IF_ADDRESS_SIZE:0] occupancy,
    output logic                     full,
    output logic                     empty,
    output logic                     row_loaded,
    output logic                     load_done
);

    localparam int unsigned c_addr_w = IF_ADDRESS_SIZE + 1;
    localparam logic [c_addr_w-1:0] c_cells = c_addr_w'(CELL_NUMS);

    load_state_t r_state;
    load_state_t w_state_next;
    logic        w_done_next;

    logic                    r_wr_en;
    logic [c_addr_w-1:0]     r_wr_addr;
    logic [IF_CELL_SIZE-1:0] r_wr_data;
    logic                    r_row_loaded;
    logic                    r_load_done;
    logic [c_addr_w-1:0]     r_occupancy;
    logic                    r_full;
    logic                    r_empty;

    logic                    w_ready;
    logic                    w_accept;
    logic [c_addr_w-1:0]     w_ptr;
    logic [c_addr_w-1:0]     w_occ_plus;
    logic [c_addr_w-1:0]     w_release;
    logic [c_addr_w-1:0]     w_occ_next;

    // Ready depends only on registered state, never on this cycle's release
    assign w_ready  = (r_state == c_load) && !r_full;
    assign w_accept = in_valid && w_ready;

    // Release may never take more cells than are held after this cycle's write
    assign w_occ_plus = r_occupancy + c_addr_w'(w_accept);
    assign w_release  = !release_en ? '0 :
                        (release_num > w_occ_plus) ? w_occ_plus : release_num;
    assign w_occ_next = w_occ_plus - w_release;

    wrap_pointer_counter #(
        .WIDTH   (c_addr_w),
        .MODULUS (CELL_NUMS)
    ) u_wr_ptr (
        .clk      (clk),
        .rst      (rst),
        .i_inc_en (w_accept),
        .o_count  (w_ptr)
    );

    // Next-state logic: arm on start, drain after the last cell, finish when empty
    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        case (r_state)
            c_idle: begin
                if (start) w_state_next = c_load;
            end
            c_load: begin
                if (w_accept && in_last) w_state_next = c_drain;
            end
            c_drain: begin
                if (r_occupancy == '0) begin
                    w_state_next = c_idle;
                    w_done_next  = 1'b1;
                end
            end
            default: w_state_next = c_idle;
        endcase
    end

    // State register and registered completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_idle;
            r_load_done <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_load_done <= w_done_next;
        end
    end

    // Write port, row marker and occupancy bookkeeping; address/data hold between writes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_row_loaded <= 1'b0;
            r_occupancy  <= '0;
            r_full       <= 1'b0;
            r_empty      <= 1'b1;
        end else begin
            r_wr_en      <= w_accept;
            r_row_loaded <= w_accept && in_eol;
            if (w_accept) begin
                r_wr_addr <= w_ptr;
                r_wr_data <= in_data;
            end
            r_occupancy <= w_occ_next;
            r_full      <= (w_occ_next == c_cells);
            r_empty     <= (w_occ_next == '0);
        end
    end

    assign in_ready        = w_ready;
    assign scratch_wr_en   = r_wr_en;
    assign scratch_wr_addr = r_wr_addr;
    assign scratch_wr_data = r_wr_data;
    assign write_cnt_if    = r_wr_en;
    assign write_addr_if   = w_ptr;
    assign occupancy       = r_occupancy;
    assign full            = r_full;
    assign empty           = r_empty;
    assign row_loaded      = r_row_loaded;
    assign load_done       = r_load_done;

endmodule : if_scratch_loader
`default_nettype wire

// File: doc/if_scratch_loader.md
# if_scratch_loader

Write-side controller for the input-feature-map scratchpad. Accepts IF cells from the upstream buffer over a valid/ready handshake and writes them into a circular scratchpad of `CELL_NUMS` cells. Tracks occupancy and releases cells when the checker stage reports them consumed. Drives that stage's `write_cnt_if` and `write_addr_if` inputs, and reports end of a feature-map row and end of stream.

## Interface
Parameters:
- `IF_CELL_SIZE`, 8, data width of one IF cell
- `IF_ADDRESS_SIZE`, 8, address bus is `IF_ADDRESS_SIZE+1` bits wide
- `CELL_NUMS`, 8, scratchpad depth in cells; legal range 2 .. 2^IF_ADDRESS_SIZE

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  pulse; arms the loader for one stream
- `in_valid`  in  1  upstream cell valid
- `in_data`  in  `IF_CELL_SIZE`  upstream cell
- `in_last`  in  1  qualifies the final cell of the stream
- `in_eol`  in  1  qualifies the last cell of a feature-map row
- `in_ready`  out  1  loader can accept
- `release_en`  in  1  checker frees cells this cycle
- `release_num`  in  `IF_ADDRESS_SIZE+1`  number of cells freed
- `scratch_wr_en`  out  1  scratchpad write strobe
- `scratch_wr_addr`  out  `IF_ADDRESS_SIZE+1`  scratchpad write address
- `scratch_wr_data`  out  `IF_CELL_SIZE`  scratchpad write data
- `write_cnt_if`  out  1  one-cycle pulse per committed write, to the checker
- `write_addr_if`  out  `IF_ADDRESS_SIZE+1`  next write pointer, to the checker
- `occupancy`  out  `IF_ADDRESS_SIZE+1`  valid cells held
- `full`, `empty`  out  1  occupancy flags
- `row_loaded`  out  1  pulse: an `in_eol` cell was committed
- `load_done`  out  1  pulse: stream finished and fully drained

## Operation
- FSM states: IDLE, LOAD, DRAIN.
- IDLE → LOAD on `start`.
- LOAD → DRAIN on acceptance of a cell with `in_last`=1.
- DRAIN → IDLE when `occupancy` reaches 0; `load_done` pulses on that transition.
- `start` outside IDLE is ignored.
- `in_ready` = (state==LOAD) && !`full`. It is a function of registers only; there is no same-cycle bypass from `release_en`.
- Accept occurs when `in_valid` && `in_ready`. On accept:
  - register the write onto `scratch_wr_*`;
  - advance the write pointer;
  - pulse `write_cnt_if`;
  - pulse `row_loaded` if `in_eol`.
- Pointer wraps from `CELL_NUMS-1` to 0. `write_addr_if` always equals the pointer value after the committed write.
- Occupancy update: `occupancy_next` = `occupancy` + accept − min(`release_num`, `occupancy`+accept).
  - Release is honoured in IDLE, LOAD and DRAIN.
  - `release_num` greater than what is held clamps. Occupancy never underflows.
- Simultaneous accept and release: both apply in the same cycle.
  - With `occupancy`=`CELL_NUMS` and release 1, no accept happens that cycle, because `in_ready` was low.
- `full` = (`occupancy`==`CELL_NUMS`); `empty` = (`occupancy`==0). Both are registered.
- Reset mid-stream:
  - returns to IDLE;
  - clears pointer and occupancy;
  - drops any in-flight write strobe;
  - issues no `load_done`.

## Timing
- Reset values:
  - state IDLE;
  - `in_ready`=0, `scratch_wr_en`=0, `write_cnt_if`=0;
  - `scratch_wr_addr`=0, `scratch_wr_data`=0, `write_addr_if`=0;
  - `occupancy`=0, `full`=0, `empty`=1;
  - `row_loaded`=0, `load_done`=0.
- Write latency: the accept in cycle N produces `scratch_wr_en`, `write_cnt_if` and `row_loaded` high in cycle N+1. `write_addr_if` and `occupancy` update in N+1.
- Release applied in cycle N is visible in `occupancy`/`full` at N+1. `in_ready` can rise at N+1.
- Sustained throughput is 1 cell/cycle while not full.
- `start` in cycle N gives `in_ready` high at N+1.
- `load_done` is high exactly one cycle, the cycle after `occupancy` first reads 0 in DRAIN.

## Structure
- Shared package: FSM state encoding (IDLE/LOAD/DRAIN) and the pointer-wrap helper, reused by the filter-side loader.
- One sub-module: `wrap_pointer_counter`, a parameterised modulo-`CELL_NUMS` counter with increment enable and sync reset.
- Occupancy arithmetic, flags and FSM stay in the top.

## Test plan
- Reset then `start`; stream 5 cells 0x11..0x15, last has `in_last` → writes to addr 0..4, `write_addr_if`=5, no release.
  - Then release 5 → `occupancy` 0, `load_done` pulses once, FSM IDLE.
- Fill to 8 with no release → `full`=1, `in_ready`=0 while `in_valid` is held.
  - `release_en` with `release_num`=1 → `in_ready`=1 the next cycle; 9th cell written to addr 0 (wrap).
- Occupancy 3, accept plus `release_num`=2 in the same cycle → `occupancy`=2 next cycle.
- `release_num`=7 at occupancy 2 → `occupancy` clamps to 0, `empty`=1, no underflow.
- Cell with `in_eol`=1 → `row_loaded` pulses aligned with its `write_cnt_if`.
- `rst` asserted mid-LOAD at occupancy 4 → all outputs at reset values next cycle, no `load_done`; new `start` resumes writing at addr 0.
